// File: rtl/score_digit_sequencer.sv
// rtl/score_digit_sequencer.sv - binary score to BCD with frame-synchronous
// double buffering and per-pixel glyph addressing for the score field.
module score_digit_sequencer #(
  parameter int ORIGIN_X = 560,
  parameter int ORIGIN_Y = 8
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [9:0] score,
  input  logic       score_load,
  output logic       busy,
  input  logic       frame_start,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [3:0] digit_sel,
  output logic [3:0] glyph_row,
  output logic [3:0] glyph_col,
  input  logic [5:0] glyph_pix,
  output logic       score_on,
  output logic [5:0] score_color
);

  localparam logic [9:0] X_LO = 10'(ORIGIN_X);
  localparam logic [9:0] X_HI = 10'(ORIGIN_X + 48);
  localparam logic [9:0] Y_LO = 10'(ORIGIN_Y);
  localparam logic [9:0] Y_HI = 10'(ORIGIN_Y + 14);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  bin_q, bin_d;
  logic [11:0] bcd_q, bcd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [11:0] pending_q, pending_d;
  logic        pending_valid_q, pending_valid_d;
  logic [11:0] shown_q, shown_d;
  logic        score_on_q, score_on_d;
  logic [5:0]  score_color_q, score_color_d;

  logic [11:0] adj;
  logic [21:0] shifted;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q         <= S_IDLE;
      bin_q           <= '0;
      bcd_q           <= '0;
      cnt_q           <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      shown_q         <= '0;
      score_on_q      <= 1'b0;
      score_color_q   <= '0;
    end else begin
      state_q         <= state_d;
      bin_q           <= bin_d;
      bcd_q           <= bcd_d;
      cnt_q           <= cnt_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      shown_q         <= shown_d;
      score_on_q      <= score_on_d;
      score_color_q   <= score_color_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    bin_d           = bin_q;
    bcd_d           = bcd_q;
    cnt_d           = cnt_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    shown_d         = shown_q;
    adj             = bcd_q;
    shifted         = '0;

    case (state_q)
      S_IDLE: begin
        if (score_load) begin
          bin_d   = (score > 10'd999) ? 10'd999 : score;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = S_CONVERT;
        end
      end
      S_CONVERT: begin
        for (int i = 0; i < 3; i++) begin
          if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        shifted = {adj, bin_q} << 1;
        bcd_d   = shifted[21:10];
        bin_d   = shifted[9:0];
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == 4'd9) state_d = S_DONE;
      end
      S_DONE: begin
        pending_d = bcd_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Frame swap sees the old pending value; a coincident DONE re-arms valid.
    if (frame_start && pending_valid_q) begin
      shown_d         = pending_q;
      pending_valid_d = 1'b0;
    end
    if (state_q == S_DONE) pending_valid_d = 1'b1;
  end

  assign busy = (state_q != S_IDLE);

  logic [5:0] rx;
  logic [3:0] ry;
  logic       in_field, active, blank;
  logic [1:0] slot;
  logic [3:0] col, digit;

  always_comb begin
    rx       = 6'(DrawX - X_LO);
    ry       = 4'(DrawY - Y_LO);
    in_field = (DrawX >= X_LO) && (DrawX < X_HI) && (DrawY >= Y_LO) && (DrawY < Y_HI);
    slot     = rx[5:4];
    col      = rx[3:0];
    active   = in_field && (col < 4'd14);

    digit = 4'd0;
    blank = 1'b0;
    case (slot)
      2'd0: begin
        digit = shown_q[11:8];
        blank = (shown_q[11:8] == 4'd0);
      end
      2'd1: begin
        digit = shown_q[7:4];
        blank = (shown_q[11:8] == 4'd0) && (shown_q[7:4] == 4'd0);
      end
      2'd2: digit = shown_q[3:0];
      default: digit = 4'd0;
    endcase

    digit_sel     = active ? digit : 4'd0;
    glyph_col     = active ? col : 4'd0;
    glyph_row     = active ? ry : 4'd0;
    score_on_d    = active && !blank && (glyph_pix != 6'd0);
    score_color_d = score_on_d ? glyph_pix : 6'd0;
  end

  assign score_on    = score_on_q;
  assign score_color = score_color_q;

endmodule

// File: tb/tb_score_digit_sequencer.sv
// tb/tb_score_digit_sequencer.sv - directed bench for score_digit_sequencer.
module tb_score_digit_sequencer;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [9:0] score = '0;
  logic       score_load = 1'b0;
  logic       busy;
  logic       frame_start = 1'b0;
  logic [9:0] DrawX = '0;
  logic [9:0] DrawY = '0;
  logic [3:0] digit_sel, glyph_row, glyph_col;
  logic [5:0] glyph_pix;
  logic       score_on;
  logic [5:0] score_color;

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  score_digit_sequencer #(.ORIGIN_X(560), .ORIGIN_Y(8)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .score(score), .score_load(score_load),
    .busy(busy), .frame_start(frame_start), .DrawX(DrawX), .DrawY(DrawY),
    .digit_sel(digit_sel), .glyph_row(glyph_row), .glyph_col(glyph_col),
    .glyph_pix(glyph_pix), .score_on(score_on), .score_color(score_color)
  );

  // Synthetic font: colour index (digit + row + col) mod 7.
  function automatic logic [5:0] font(input logic [3:0] d, input logic [3:0] r, input logic [3:0] c);
    return 6'((int'(d) + int'(r) + int'(c)) % 7);
  endfunction

  assign glyph_pix = font(digit_sel, glyph_row, glyph_col);

  // Returns {lit, colour} for a pixel given the displayed digits.
  function automatic logic [6:0] ref_pix(input int x, input int y, input int h, input int t, input int o);
    int rx, ry, sl, c, d, p;
    bit bl;
    rx = x - 560;
    ry = y - 8;
    if (rx < 0 || rx >= 48 || ry < 0 || ry >= 14) return 7'd0;
    sl = rx / 16;
    c  = rx % 16;
    if (c >= 14) return 7'd0;
    d  = (sl == 0) ? h : (sl == 1) ? t : o;
    bl = (sl == 0 && h == 0) || (sl == 1 && h == 0 && t == 0);
    p  = (d + ry + c) % 7;
    if (bl || p == 0) return 7'd0;
    return {1'b1, 6'(p)};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [9:0] s);
    @(negedge Clk);
    score      = s;
    score_load = 1'b1;
    @(negedge Clk);
    score_load = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(negedge Clk);
    end
  endtask

  task automatic pulse_frame();
    @(negedge Clk);
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
  endtask

  task automatic check_digits(input string name, input int h, input int t, input int o);
    @(negedge Clk);
    DrawX = 10'd560; DrawY = 10'd8; #1;
    chk({name, " hundreds"}, int'(digit_sel), h);
    DrawX = 10'd576; #1;
    chk({name, " tens"}, int'(digit_sel), t);
    DrawX = 10'd592; #1;
    chk({name, " ones"}, int'(digit_sel), o);
  endtask

  task automatic scan_field(input string name, input int h, input int t, input int o);
    logic [6:0] e;
    int bad;
    bad = 0;
    for (int y = 6; y < 24; y++) begin
      for (int x = 556; x < 612; x++) begin
        @(negedge Clk);
        DrawX = 10'(x);
        DrawY = 10'(y);
        @(posedge Clk);
        #1;
        e = ref_pix(x, y, h, t, o);
        tests++;
        if ({score_on, score_color} != e) begin
          fails++;
          bad++;
          if (bad <= 4)
            $display("FAIL %s pixel (%0d,%0d): on/colour %0d/%0d, expected %0d/%0d",
                     name, x, y, score_on, score_color, e[6], e[5:0]);
        end
      end
    end
  endtask

  typedef struct {
    logic [9:0] x, y;
    logic [3:0] dsel, row, col;
    logic       on;
    logic [5:0] color;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int n;

    // Hand-computed vectors with shown = 0,5,7.
    vecs[0]  = '{10'd560, 10'd8,  4'd0, 4'd0,  4'd0,  1'b0, 6'd0};
    vecs[1]  = '{10'd564, 10'd10, 4'd0, 4'd2,  4'd4,  1'b0, 6'd0};
    vecs[2]  = '{10'd580, 10'd8,  4'd5, 4'd0,  4'd4,  1'b1, 6'd2};
    vecs[3]  = '{10'd576, 10'd8,  4'd5, 4'd0,  4'd0,  1'b1, 6'd5};
    vecs[4]  = '{10'd578, 10'd9,  4'd5, 4'd1,  4'd2,  1'b1, 6'd1};
    vecs[5]  = '{10'd577, 10'd9,  4'd5, 4'd1,  4'd1,  1'b0, 6'd0};
    vecs[6]  = '{10'd590, 10'd8,  4'd0, 4'd0,  4'd0,  1'b0, 6'd0};
    vecs[7]  = '{10'd591, 10'd20, 4'd0, 4'd0,  4'd0,  1'b0, 6'd0};
    vecs[8]  = '{10'd592, 10'd8,  4'd7, 4'd0,  4'd0,  1'b0, 6'd0};
    vecs[9]  = '{10'd605, 10'd21, 4'd7, 4'd13, 4'd13, 1'b1, 6'd5};
    vecs[10] = '{10'd608, 10'd8,  4'd0, 4'd0,  4'd0,  1'b0, 6'd0};
    vecs[11] = '{10'd559, 10'd8,  4'd0, 4'd0,  4'd0,  1'b0, 6'd0};
    vecs[12] = '{10'd592, 10'd22, 4'd0, 4'd0,  4'd0,  1'b0, 6'd0};
    vecs[13] = '{10'd596, 10'd7,  4'd0, 4'd0,  4'd0,  1'b0, 6'd0};
    vecs[14] = '{10'd600, 10'd11, 4'd7, 4'd3,  4'd8,  1'b1, 6'd4};
    vecs[15] = '{10'd570, 10'd12, 4'd0, 4'd4,  4'd10, 1'b0, 6'd0};

    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    #1;
    chk("reset busy", int'(busy), 0);
    chk("reset score_on", int'(score_on), 0);
    chk("reset score_color", int'(score_color), 0);
    scan_field("reset", 0, 0, 0);

    // Score 57: busy width, buffered swap, pixel table.
    do_load(10'd57);
    wait_idle(n);
    chk("busy cycles 57", n, 11);
    check_digits("before frame", 0, 0, 0);
    pulse_frame();
    check_digits("57", 0, 5, 7);
    for (int i = 0; i < 16; i++) begin
      @(negedge Clk);
      DrawX = vecs[i].x;
      DrawY = vecs[i].y;
      #1;
      chk($sformatf("vec%0d digit_sel", i), int'(digit_sel), int'(vecs[i].dsel));
      chk($sformatf("vec%0d glyph_row", i), int'(glyph_row), int'(vecs[i].row));
      chk($sformatf("vec%0d glyph_col", i), int'(glyph_col), int'(vecs[i].col));
      @(posedge Clk);
      #1;
      chk($sformatf("vec%0d score_on", i), int'(score_on), int'(vecs[i].on));
      chk($sformatf("vec%0d score_color", i), int'(score_color), int'(vecs[i].color));
    end

    // Saturation.
    do_load(10'd1023);
    wait_idle(n);
    chk("busy cycles 1023", n, 11);
    pulse_frame();
    check_digits("1023", 9, 9, 9);
    scan_field("999", 9, 9, 9);

    // Load during busy is dropped.
    do_load(10'd123);
    repeat (3) @(negedge Clk);
    score      = 10'd456;
    score_load = 1'b1;
    @(negedge Clk);
    score_load = 1'b0;
    wait_idle(n);
    chk("busy tail after dropped load", n, 7);
    @(negedge Clk);
    chk("no queued load", int'(busy), 0);
    pulse_frame();
    check_digits("123", 1, 2, 3);

    // DONE coincident with frame_start: old pending shown, new one next frame.
    do_load(10'd45);
    wait_idle(n);
    do_load(10'd678);
    repeat (10) @(negedge Clk);
    chk("in DONE", int'(busy), 1);
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
    chk("idle after DONE", int'(busy), 0);
    check_digits("coincident", 0, 4, 5);
    scan_field("045", 0, 4, 5);
    pulse_frame();
    check_digits("next frame", 6, 7, 8);
    pulse_frame();
    check_digits("frame without pending", 6, 7, 8);

    // Reset in the 5th CONVERT cycle.
    do_load(10'd321);
    repeat (4) @(negedge Clk);
    chk("busy before abort", int'(busy), 1);
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    chk("busy after abort", int'(busy), 0);
    repeat (12) @(negedge Clk);
    chk("still idle after abort", int'(busy), 0);
    pulse_frame();
    check_digits("after abort", 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
